regfile_sequencer: RTL and testbench
====================================

// Module: regfile_sequencer
// PURPOSE
//   Command-driven initiator for the 8x16 register file (regfile). Accepts one
//   register operation per valid/ready handshake (load-immediate, move, swap,
//   read-out), drives regfile's writenum/write/readnum/data_in, and samples its
//   combinational data_out. Sits between the control/debug path and the regfile.
// PARAMETERS
//   DATA_W  16  register width; must match regfile data_in/data_out
//   ADDR_W  3   register index width (2**ADDR_W registers)
// PORTS
//   clk         in   1       rising-edge clock, shared with regfile
//   rst_n       in   1       asynchronous, active-low reset
//   cmd_valid   in   1       command present
//   cmd_ready   out  1       sequencer can accept a command (IDLE only)
//   cmd_op      in   2       00 LOADI, 01 MOV, 10 SWAP, 11 READ
//   cmd_rd      in   ADDR_W  destination register
//   cmd_rs      in   ADDR_W  source register
//   cmd_imm     in   DATA_W  immediate for LOADI
//   rsp_valid   out  1       READ result available
//   rsp_ready   in   1       consumer takes result
//   rsp_data    out  DATA_W  READ result
//   done        out  1       1-cycle pulse when a command retires
//   rf_data_in  out  DATA_W  to regfile data_in
//   rf_writenum out  ADDR_W  to regfile writenum
//   rf_write    out  1       to regfile write
//   rf_readnum  out  ADDR_W  to regfile readnum
//   rf_data_out in   DATA_W  from regfile data_out (combinational read)
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE; cmd_ready=0, rsp_valid=0, done=0,
//     rf_write=0, rf_writenum=0, rf_readnum=0, rf_data_in=0, rsp_data=0,
//     latched op/rd/rs/imm/tmp_a/tmp_b=0. Regfile contents are NOT reset.
//   cmd_ready = (state==IDLE) & rst_n. Accept on clk edge with cmd_valid&cmd_ready;
//     latch op, rd, rs, imm. cmd_valid while busy is ignored (no queue).
//   States: IDLE, RD_S, RD_D, WR_A, WR_B, RESP.
//   RD_S: rf_readnum=rs; tmp_a<=rf_data_out at edge. RD_D: rf_readnum=rd;
//     tmp_b<=rf_data_out. Outside RD_D, rf_readnum holds latched rs.
//   WR_A: rf_write=1, rf_writenum=rd, rf_data_in=(op==LOADI)?imm:tmp_a.
//   WR_B: rf_write=1, rf_writenum=rs, rf_data_in=tmp_b. rf_write=0 elsewhere.
//   Transitions: LOADI IDLE->WR_A->IDLE; MOV IDLE->RD_S->WR_A->IDLE;
//     SWAP IDLE->RD_S->RD_D->WR_A->WR_B->IDLE; READ IDLE->RD_S->RESP.
//   RESP: rsp_valid=1, rsp_data=tmp_a, held stable until rsp_ready; on
//     rsp_valid&rsp_ready edge -> IDLE. rsp_valid only ever asserted in RESP.
//   done: asserted for the single cycle after the final write (LOADI/MOV/SWAP)
//     or after the RESP handshake (READ), i.e. in the first IDLE cycle.
//   Latency accept->retire edge: LOADI 1, MOV 2, SWAP 4, READ 2+stall cycles.
//   Throughput: back-to-back commands allowed; next accept in the done cycle.
//   SWAP with rd==rs: runs full sequence, register value unchanged.
//   Reads are of values committed before the read cycle (writes are sequential,
//     so MOV/SWAP never observe their own write).
//   Reset mid-op aborts immediately; a SWAP aborted after WR_A leaves Rd updated
//     and Rs unchanged — defined, not recovered.
// TESTING (bench instantiates real regfile + this block)
//   LOADI rd=3 imm=0xBEEF; READ rs=3 -> rsp_data=0xBEEF, done pulse once each.
//   LOADI R1=0x1111, R2=0x2222; SWAP rd=1 rs=2; READ R1,R2 -> 0x2222, 0x1111.
//   MOV rd=5 rs=3 (R3=0xBEEF) -> READ R5=0xBEEF, R3 still 0xBEEF; 2-cycle latency.
//   READ with rsp_ready low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0,
//     no rf_write; retire on cycle rsp_ready rises.
//   cmd_valid held high during SWAP with different fields -> ignored; only one
//     accept per IDLE; SWAP rd=rs=4 leaves R4 unchanged.
//   rst_n low in SWAP WR_B -> rf_write drops asynchronously, outputs at reset
//     values; R1 new, R2 old; next command accepted normally.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Command-driven initiator for the 8x16 register file: sequences LOADI/MOV/SWAP/READ
// into regfile read/write port activity and returns READ results over a valid/ready channel.
module regfile_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [ADDR_W-1:0] rf_writenum,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_readnum,
  input  logic [DATA_W-1:0] rf_data_out
);

  localparam logic [1:0] OP_LOADI = 2'b00;
  localparam logic [1:0] OP_MOV   = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_S, RD_D, WR_A, WR_B, RESP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d, rs_q, rs_d;
  logic [DATA_W-1:0]   imm_q, imm_d, tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
  logic                rsp_valid_q, rsp_valid_d, done_q, done_d, rf_write_q, rf_write_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d, rf_data_in_q, rf_data_in_d;
  logic [ADDR_W-1:0]   rf_writenum_q, rf_writenum_d, rf_readnum_q, rf_readnum_d;
  logic                accept;

  assign cmd_ready   = (state_q == IDLE) & rst_n;
  assign accept      = cmd_valid & cmd_ready;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign done        = done_q;
  assign rf_data_in  = rf_data_in_q;
  assign rf_writenum = rf_writenum_q;
  assign rf_write    = rf_write_q;
  assign rf_readnum  = rf_readnum_q;

  // Next state plus port values for the state being entered, so every port is a flop.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rd_d          = rd_q;
    rs_d          = rs_q;
    imm_d         = imm_q;
    tmp_a_d       = tmp_a_q;
    tmp_b_d       = tmp_b_q;
    done_d        = 1'b0;
    rsp_data_d    = rsp_data_q;
    rf_data_in_d  = rf_data_in_q;
    rf_writenum_d = rf_writenum_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          rd_d    = cmd_rd;
          rs_d    = cmd_rs;
          imm_d   = cmd_imm;
          state_d = (cmd_op == OP_LOADI) ? WR_A : RD_S;
        end
      end
      RD_S: begin
        tmp_a_d = rf_data_out;
        case (op_q)
          OP_MOV:  state_d = WR_A;
          OP_SWAP: state_d = RD_D;
          OP_READ: state_d = RESP;
          default: state_d = IDLE;
        endcase
      end
      RD_D: begin
        tmp_b_d = rf_data_out;
        state_d = WR_A;
      end
      WR_A: begin
        if (op_q == OP_SWAP) begin
          state_d = WR_B;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      WR_B: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rf_write_d   = (state_d == WR_A) || (state_d == WR_B);
    rsp_valid_d  = (state_d == RESP);
    rf_readnum_d = (state_d == RD_D) ? rd_d : rs_d;
    if (state_d == WR_A) begin
      rf_writenum_d = rd_d;
      rf_data_in_d  = (op_d == OP_LOADI) ? imm_d : tmp_a_d;
    end else if (state_d == WR_B) begin
      rf_writenum_d = rs_d;
      rf_data_in_d  = tmp_b_d;
    end
    if (state_d == RESP) rsp_data_d = tmp_a_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= 2'b00;
      rd_q          <= '0;
      rs_q          <= '0;
      imm_q         <= '0;
      tmp_a_q       <= '0;
      tmp_b_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      done_q        <= 1'b0;
      rf_write_q    <= 1'b0;
      rf_writenum_q <= '0;
      rf_readnum_q  <= '0;
      rf_data_in_q  <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      rs_q          <= rs_d;
      imm_q         <= imm_d;
      tmp_a_q       <= tmp_a_d;
      tmp_b_q       <= tmp_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      done_q        <= done_d;
      rf_write_q    <= rf_write_d;
      rf_writenum_q <= rf_writenum_d;
      rf_readnum_q  <= rf_readnum_d;
      rf_data_in_q  <= rf_data_in_d;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer with an 8x16 register file model attached; results are
// checked against an array model of register contents and a per-op latency table.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs;
  logic [15:0] cmd_imm;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        done;
  logic [15:0] rf_data_in, rf_data_out;
  logic [2:0]  rf_writenum, rf_readnum;
  logic        rf_write;

  int total = 0;
  int bad   = 0;

  logic [15:0] rf_mem [8];
  logic [15:0] mdl [8];

  always #5 clk = ~clk;

  regfile_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .done(done), .rf_data_in(rf_data_in), .rf_writenum(rf_writenum),
    .rf_write(rf_write), .rf_readnum(rf_readnum), .rf_data_out(rf_data_out)
  );

  // Register file: clocked write, combinational read, contents not reset.
  always @(posedge clk) if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
  assign rf_data_out = rf_mem[rf_readnum];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one command at the current negedge and follow it to retirement.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [15:0] imm, input int stall, input bit hold);
    int lat, st;
    logic [15:0] exp_rsp, t;
    lat = (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : (op == 2'd2) ? 4 : 2 + stall;
    exp_rsp = mdl[rs];
    st = 0;
    chk("ready_in_idle", 32'(cmd_ready), 32'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    rsp_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k <= lat + 5; k++) begin
      @(negedge clk);
      chk("done", 32'(done), 32'(k == lat));
      chk("rsp_valid", 32'(rsp_valid), 32'(op == 2'd3 && k >= 1 && k < lat));
      if (k < lat) chk("ready_busy", 32'(cmd_ready), 32'(0));
      if (rsp_valid) begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_rsp));
        chk("no_write_resp", 32'(rf_write), 32'(0));
        if (st < stall) begin
          st++;
          rsp_ready = 1'b0;
        end else begin
          rsp_ready = 1'b1;
        end
      end
      if (done || k >= lat) begin
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        break;
      end
      cmd_valid = hold;
      cmd_op  = 2'($urandom_range(0, 3));
      cmd_rd  = 3'($urandom_range(0, 7));
      cmd_rs  = 3'($urandom_range(0, 7));
      cmd_imm = 16'($urandom);
    end
    case (op)
      2'd0: mdl[rd] = imm;
      2'd1: mdl[rd] = mdl[rs];
      2'd2: begin t = mdl[rd]; mdl[rd] = mdl[rs]; mdl[rs] = t; end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] old2;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 2'd0; cmd_rd = 3'd0; cmd_rs = 3'd0; cmd_imm = 16'd0;
    foreach (mdl[i]) mdl[i] = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rf_write", 32'(rf_write), 32'(0));
    chk("rst_readnum", 32'(rf_readnum), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 8; i++) run_cmd(2'd0, 3'(i), 3'd0, 16'(16'h1010 * i + 16'h0005), 0, 1'b0);
    run_cmd(2'd0, 3'd3, 3'd0, 16'hBEEF, 0, 1'b0);
    run_cmd(2'd3, 3'd0, 3'd3, 16'd0, 0, 1'b0);
    run_cmd(2'd0, 3'd1, 3'd0, 16'h1111, 0, 1'b0);
    run_cmd(2'd0, 3'd2, 3'd0, 16'h2222, 0, 1'b0);
    run_cmd(2'd2, 3'd1, 3'd2, 16'd0, 0, 1'b0);
    run_cmd(2'd3, 3'd0, 3'd1, 16'd0, 0, 1'b0);
    run_cmd(2'd3, 3'd0, 3'd2, 16'd0, 0, 1'b0);
    chk("swap_r1_value", 32'(mdl[1]), 32'(16'h2222));
    run_cmd(2'd1, 3'd5, 3'd3, 16'd0, 0, 1'b0);
    run_cmd(2'd3, 3'd0, 3'd5, 16'd0, 0, 1'b0);
    run_cmd(2'd3, 3'd0, 3'd3, 16'd0, 5, 1'b0);
    run_cmd(2'd2, 3'd1, 3'd2, 16'd0, 0, 1'b1);
    run_cmd(2'd2, 3'd4, 3'd4, 16'd0, 0, 1'b1);
    run_cmd(2'd3, 3'd0, 3'd4, 16'd0, 0, 1'b0);

    // Reset during the second write of a SWAP R1<->R2.
    old2 = mdl[2];
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_rd = 3'd1; cmd_rs = 3'd2;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("wrb_write", 32'(rf_write), 32'(1));
    chk("wrb_writenum", 32'(rf_writenum), 32'(2));
    rst_n = 1'b0;
    #1;
    chk("abort_rf_write", 32'(rf_write), 32'(0));
    chk("abort_writenum", 32'(rf_writenum), 32'(0));
    chk("abort_data_in", 32'(rf_data_in), 32'(0));
    chk("abort_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    mdl[1] = old2;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_cmd(2'd3, 3'd0, 3'd1, 16'd0, 0, 1'b0);
    run_cmd(2'd3, 3'd0, 3'd2, 16'd0, 0, 1'b0);

    for (int n = 0; n < 40; n++)
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) run_cmd(2'd3, 3'd0, 3'(i), 16'd0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
